// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS-Lite pipeline control blocks.
package mips_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } stall_state_e;

    // Longest stall that a CNT_W-bit length field can request.
    function automatic int unsigned stall_max(input int unsigned cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall controller: freezes PC/IF-ID for a programmable number of cycles on a
// RAW hazard unless forwarding covers every source; flush aborts any stall.
module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned PERF_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hazard_i,
    input  logic [CNT_W-1:0]   stall_len_i,
    input  logic [NUM_SRC-1:0] fwd_i,
    input  logic               fwd_mode_i,
    input  logic               flush_i,
    input  logic               clr_perf_i,
    output logic               stall_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   remaining_o,
    output logic [PERF_W-1:0]  perf_stall_cnt_o,
    output logic [PERF_W-1:0]  perf_hazard_cnt_o,
    output logic [PERF_W-1:0]  perf_fwd_cnt_o
);

    stall_state_e     state, state_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic             fwd_full;
    logic [CNT_W-1:0] eff_len;
    logic             hazard_inc, fwd_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        stall_o     = 1'b0;
        busy_o      = 1'b0;
        hazard_inc  = 1'b0;
        fwd_inc     = 1'b0;
        fwd_full    = fwd_mode_i & (&fwd_i);
        eff_len     = fwd_full ? '0 : stall_len_i;

        case (state)
            IDLE: begin
                if (!flush_i) begin
                    // The first stall cycle is the detect cycle itself, so STALL only covers the rest.
                    if (hazard_i && (eff_len != '0)) begin
                        stall_o    = 1'b1;
                        hazard_inc = 1'b1;
                        if (eff_len > CNT_W'(1)) begin
                            state_n     = STALL;
                            remaining_n = eff_len - 1'b1;
                        end
                    end
                    fwd_inc = hazard_i & fwd_full & (stall_len_i != '0);
                end
            end
            STALL: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    state_n     = IDLE;
                    remaining_n = '0;
                end else begin
                    stall_o = 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state_n     = IDLE;
                        remaining_n = '0;
                    end else begin
                        remaining_n = remaining - 1'b1;
                    end
                end
            end
            default: begin
                state_n     = IDLE;
                remaining_n = '0;
            end
        endcase

        if (!reset) begin
            stall_o    = 1'b0;
            busy_o     = 1'b0;
            hazard_inc = 1'b0;
            fwd_inc    = 1'b0;
        end
    end

    assign remaining_o = (state == STALL) ? remaining : '0;

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_o),
        .clr   (clr_perf_i),
        .cnt   (perf_stall_cnt_o)
    );

    sat_counter #(.W(PERF_W)) u_hazard_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hazard_inc),
        .clr   (clr_perf_i),
        .cnt   (perf_hazard_cnt_o)
    );

    sat_counter #(.W(PERF_W)) u_fwd_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fwd_inc),
        .clr   (clr_perf_i),
        .cnt   (perf_fwd_cnt_o)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic against a
// cycles-owed reference model with saturating counters.
module tb_hazard_stall_ctrl;
    import mips_pkg::*;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned PERF_W  = 4;
    localparam int          PMAX    = (1 << PERF_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               hazard_i;
    logic [CNT_W-1:0]   stall_len_i;
    logic [NUM_SRC-1:0] fwd_i;
    logic               fwd_mode_i;
    logic               flush_i;
    logic               clr_perf_i;
    logic               stall_o;
    logic               busy_o;
    logic [CNT_W-1:0]   remaining_o;
    logic [PERF_W-1:0]  perf_stall_cnt_o;
    logic [PERF_W-1:0]  perf_hazard_cnt_o;
    logic [PERF_W-1:0]  perf_fwd_cnt_o;

    hazard_stall_ctrl #(
        .CNT_W   (CNT_W),
        .NUM_SRC (NUM_SRC),
        .PERF_W  (PERF_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .hazard_i          (hazard_i),
        .stall_len_i       (stall_len_i),
        .fwd_i             (fwd_i),
        .fwd_mode_i        (fwd_mode_i),
        .flush_i           (flush_i),
        .clr_perf_i        (clr_perf_i),
        .stall_o           (stall_o),
        .busy_o            (busy_o),
        .remaining_o       (remaining_o),
        .perf_stall_cnt_o  (perf_stall_cnt_o),
        .perf_hazard_cnt_o (perf_hazard_cnt_o),
        .perf_fwd_cnt_o    (perf_fwd_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: number of stall cycles still owed after the current one, plus counter values.
    int owed  = 0;
    int m_stl = 0;
    int m_haz = 0;
    int m_fwd = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat_next(input int c, input bit inc, input bit clr);
        if (clr) return 0;
        if (inc && c < PMAX) return c + 1;
        return c;
    endfunction

    // Drive one cycle of inputs, check at the falling edge, advance the model at the rising edge.
    task automatic cycle(input bit h, input int len, input int f, input bit m,
                         input bit fl, input bit cl);
        bit ff;
        int eff;
        bit exp_stall;
        bit hz;
        bit fw;
        int nxt;
        hazard_i    = h;
        stall_len_i = CNT_W'(len);
        fwd_i       = NUM_SRC'(f);
        fwd_mode_i  = m;
        flush_i     = fl;
        clr_perf_i  = cl;
        @(negedge clk);
        ff        = m && (f == 3);
        eff       = ff ? 0 : len;
        exp_stall = 1'b0;
        hz        = 1'b0;
        fw        = 1'b0;
        nxt       = 0;
        if (fl) begin
            nxt = 0;
        end else if (owed > 0) begin
            exp_stall = 1'b1;
            nxt       = owed - 1;
        end else begin
            exp_stall = h && (eff > 0);
            hz        = exp_stall;
            fw        = h && ff && (len > 0);
            nxt       = exp_stall ? eff - 1 : 0;
        end
        check_eq("stall", int'(stall_o), int'(exp_stall));
        check_eq("busy", int'(busy_o), (owed > 0) ? 1 : 0);
        check_eq("remaining", int'(remaining_o), owed);
        check_eq("perf_stall", int'(perf_stall_cnt_o), m_stl);
        check_eq("perf_hazard", int'(perf_hazard_cnt_o), m_haz);
        check_eq("perf_fwd", int'(perf_fwd_cnt_o), m_fwd);
        owed  = nxt;
        m_stl = sat_next(m_stl, exp_stall, cl);
        m_haz = sat_next(m_haz, hz, cl);
        m_fwd = sat_next(m_fwd, fw, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset       = 1'b0;
        hazard_i    = 1'b1;
        stall_len_i = 2'd3;
        fwd_i       = '0;
        fwd_mode_i  = 1'b0;
        flush_i     = 1'b0;
        clr_perf_i  = 1'b0;
        #2;
        check_eq("rst_stall_forced", int'(stall_o), 0);
        check_eq("rst_busy", int'(busy_o), 0);
        hazard_i = 1'b0;
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Stall-only pipeline: 3-cycle stall starting in the detect cycle.
        cycle(1, 3, 0, 0, 0, 0);
        idle(3);
        check_eq("nofwd_stall_total", int'(perf_stall_cnt_o), 3);
        check_eq("nofwd_hazard_total", int'(perf_hazard_cnt_o), 1);

        // Reset asserted mid-stall with two cycles left.
        cycle(1, 3, 0, 0, 0, 0);
        check_eq("pre_rst_remaining", int'(remaining_o), 2);
        hazard_i = 1'b1;
        reset    = 1'b0;
        #1;
        check_eq("midrst_stall", int'(stall_o), 0);
        check_eq("midrst_busy", int'(busy_o), 0);
        check_eq("midrst_remaining", int'(remaining_o), 0);
        check_eq("midrst_perf_stall", int'(perf_stall_cnt_o), 0);
        check_eq("midrst_perf_hazard", int'(perf_hazard_cnt_o), 0);
        hazard_i = 1'b0;
        #2 reset = 1'b1;
        owed  = 0;
        m_stl = 0;
        m_haz = 0;
        m_fwd = 0;
        @(posedge clk);
        #1;
        idle(2);

        // Full forwarding hides the hazard; partial forwarding does not.
        cycle(1, 2, 3, 1, 0, 0);
        idle(1);
        check_eq("fullfwd_fwd", int'(perf_fwd_cnt_o), 1);
        check_eq("fullfwd_hazard", int'(perf_hazard_cnt_o), 0);
        cycle(1, 2, 1, 1, 0, 0);
        idle(2);
        check_eq("partfwd_stall", int'(perf_stall_cnt_o), 2);

        // Flush on the second stall cycle, then flush together with a new hazard.
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 3, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        idle(1);
        check_eq("flush_stall_total", int'(perf_stall_cnt_o), 1);
        cycle(1, 3, 0, 0, 1, 0);
        idle(1);
        check_eq("flush_idle_hazard", int'(perf_hazard_cnt_o), 1);

        // One-cycle stall immediately followed by a two-cycle stall.
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 2, 0, 0, 0, 0);
        idle(2);
        check_eq("b2b_hazard", int'(perf_hazard_cnt_o), 2);
        check_eq("b2b_stall", int'(perf_stall_cnt_o), 3);

        // Saturation of the stall counter, then clear coinciding with a stall.
        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cycle(1, 3, 0, 0, 0, 0);
            idle(2);
        end
        check_eq("sat_stall", int'(perf_stall_cnt_o), PMAX);
        cycle(1, 3, 0, 0, 0, 1);
        check_eq("clr_over_inc", int'(perf_stall_cnt_o), 0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) < 4),
                  int'($urandom_range(0, stall_max(CNT_W))),
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised stall controller for the MIPS-Lite 5-stage pipeline. It sits beside the ID-stage hazard detector. On a RAW hazard it freezes PC/IF-ID and injects bubbles for a programmable number of cycles. Stalls are skipped when forwarding fully covers the hazard, and are aborted on a pipeline flush. Saturating performance counters track stalls, accepted hazards and forward-resolved hazards.

Parameters:
CNT_W, 2, width of stall-length field; maximum stall length is 2^CNT_W-1
NUM_SRC, 2, number of source operands checked for forwarding
PERF_W, 32, width of each performance counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
hazard_i  in  1  hazard detected for the instruction in ID this cycle
stall_len_i  in  CNT_W  stall cycles required without forwarding (0..2^CNT_W-1)
fwd_i  in  NUM_SRC  per-source: forwarding path can supply the operand
fwd_mode_i  in  1  1 = forwarding enabled, 0 = stall-only pipeline
flush_i  in  1  branch-taken/exception flush; aborts any stall
clr_perf_i  in  1  synchronous clear of all performance counters
stall_o  out  1  freeze PC and IF/ID, insert bubble into ID/EX
busy_o  out  1  1 while in STALL state
remaining_o  out  CNT_W  stall cycles left, including the current cycle (STALL only, else 0)
perf_stall_cnt_o  out  PERF_W  cycles with stall_o=1
perf_hazard_cnt_o  out  PERF_W  hazards that caused a stall
perf_fwd_cnt_o  out  PERF_W  hazards fully resolved by forwarding

Behaviour:
- Reset (reset=0, async): state IDLE, remaining reg 0, all counters 0. stall_o and busy_o are forced to 0 while reset is low.
- fwd_full = fwd_mode_i & (&fwd_i).
- eff_len = fwd_full ? 0 : stall_len_i.
- States: IDLE and STALL.
- IDLE:
  - stall_o = hazard_i & (eff_len!=0) & ~flush_i. This is combinational, so a stall starts in the detect cycle.
  - If stall_o and eff_len==1, stay IDLE. The stall lasts exactly 1 cycle.
  - If stall_o and eff_len>=2, go to STALL next cycle with remaining = eff_len-1.
  - hazard_i with eff_len==0 produces no stall.
- STALL:
  - stall_o=1 and busy_o=1.
  - remaining decrements each cycle. When remaining==1, next state is IDLE and remaining goes to 0.
  - hazard_i, stall_len_i and fwd_i are ignored in STALL.
- Total stall_o-high cycles per accepted hazard = eff_len exactly.
- After returning to IDLE, hazard_i is evaluated as a new hazard. The detector must have deasserted it once the producer has advanced.
- flush_i has highest priority in all states:
  - stall_o=0 in that cycle.
  - Next state is IDLE and remaining goes to 0.
  - No hazard or forward count is recorded that cycle.
- Performance counters:
  - perf_stall_cnt_o increments on every cycle with stall_o=1.
  - perf_hazard_cnt_o increments on an IDLE cycle where stall_o=1.
  - perf_fwd_cnt_o increments on an IDLE cycle where hazard_i & ~flush_i & fwd_full & (stall_len_i!=0).
  - All three saturate at all-ones and do not wrap.
  - clr_perf_i zeroes all three next cycle and takes priority over increments in the same cycle.
- stall_len_i=0 never stalls, regardless of forwarding.

Decomposition:
- mips_pkg: stall_state_e enum {IDLE, STALL} and localparam STALL_MAX = 2**CNT_W-1 (as a function or macro).
- Sub-module sat_counter (parameter W; inputs inc, clr; output cnt) saturates at all-ones and is instantiated three times for the performance counters.

Test Plan:
- Reset: assert reset=0 mid-stall with remaining=2 -> stall_o=0, busy_o=0 and all counters 0 immediately; still IDLE after release.
- No forwarding: fwd_mode_i=0, hazard_i pulse, stall_len_i=3 -> stall_o high for exactly 3 cycles starting in the detect cycle; remaining_o reads 0,2,1 then 0; perf_stall=3, perf_hazard=1.
- Full forwarding: fwd_mode_i=1, fwd_i=2'b11, stall_len_i=2 -> stall_o stays 0, perf_fwd=1, perf_hazard=0. Repeat with fwd_i=2'b01 -> 2-cycle stall.
- Flush: stall_len_i=3, flush_i asserted on the 2nd stall cycle -> stall_o=0 that cycle, IDLE next cycle, perf_stall=1. Also flush_i with hazard_i in IDLE -> no stall, no counts.
- Back-to-back: a 1-cycle stall, then hazard_i asserted again the cycle after the stall ends with stall_len_i=2 -> second stall of 2 cycles with no gap cycle required; perf_hazard=2, perf_stall=3.
- Saturation/clear: with PERF_W=4, run 20 stall cycles -> perf_stall=15 and holds. Assert clr_perf_i and stall_o in the same cycle -> counter reads 0 next cycle.
